axi_clock_converter: RTL and testbench
======================================

# axi_clock_converter

Single-clock AXI4 channel decoupler, 32-bit address and 256-bit data, inserted between an upstream AXI4 master (s_axi side) and a downstream AXI4 slave (m_axi side). It registers all five channels (AW, W, B, AR, R) through independent 2-entry buffers, breaking combinational valid/ready paths while sustaining full throughput. It passes payloads through unchanged and performs no protocol conversion.

## Interface
- ADDR_WIDTH, 32, address width of AW/AR.
- DATA_WIDTH, 256, data width of W/R; strobe width DATA_WIDTH/8.
- Clocking: one clock; reset is synchronous and active-low.
- s_axi_aclk  in  1  sole clock, rising edge.
- s_axi_aresetn  in  1  synchronous active-low reset.
- s_axi_awaddr/awlen/awsize/awburst/awlock/awcache/awprot/awregion/awqos  in  32/8/3/2/1/4/3/4/4  upstream write address.
- s_axi_awvalid in 1; s_axi_awready out 1  AW handshake.
- s_axi_wdata/wstrb/wlast  in  256/32/1; s_axi_wvalid in 1; s_axi_wready out 1  write data.
- s_axi_bresp out 2; s_axi_bvalid out 1; s_axi_bready in 1  write response.
- s_axi_araddr/arlen/arsize/arburst/arlock/arcache/arprot/arregion/arqos  in  same widths as AW; s_axi_arvalid in 1; s_axi_arready out 1.
- s_axi_rdata/rresp/rlast out 256/2/1; s_axi_rvalid out 1; s_axi_rready in 1.
- m_axi_* : mirror of every s_axi_* payload/valid/ready signal above with direction reversed (AW/W/AR payload+valid out, ready in; B/R payload+valid in, ready out).
- m_axi_aclk, m_axi_aresetn  in  1  present for compatibility; ignored (tie to s_axi_aclk/s_axi_aresetn).

## Operation
- Five independent channel buffers: AW, W, AR forward s→m; B, R forward m→s.
- Each buffer: 2 entries, FIFO order, payload stored bit-exact (all fields concatenated).
- in_ready = (count < 2), registered; out_valid = (count > 0); out payload = head entry, registered.
- Push on in_valid && in_ready; pop on out_valid && out_ready; simultaneous push+pop keeps count.
- Full (count=2): in_ready low; a pop frees a slot, in_ready high next cycle.
- Empty: out_valid low; payload outputs hold last value (0 after reset).
- No cross-channel dependency: W may precede AW; no burst tracking, no ID reordering; wlast/rlast/bresp/rresp passed through.
- Valid, once asserted on an output, stays asserted with stable payload until accepted (guaranteed by FIFO head).

## Timing
- Reset (s_axi_aresetn=0 at an edge): all counts 0; every valid output 0; every ready output 0; all payload outputs 0. Stored contents discarded, including mid-burst.
- First edge with aresetn=1: ready outputs rise to 1 (visible the cycle after release).
- Latency: beat accepted at edge N appears on output valid after edge N (1 cycle).
- Throughput: 1 beat/cycle per channel when downstream ready held high.
- Back-pressure: downstream ready low → 2 beats absorbed, then upstream ready low from the next cycle.

## Structure
- Package axi_cc_pkg: ADDR_WIDTH, DATA_WIDTH, STRB_WIDTH, AW/AR/W/B/R payload widths, packed struct typedefs per channel, RESP_OKAY/EXOKAY/SLVERR/DECERR constants.
- Sub-module axi_cc_chan_buf #(WIDTH): generic 2-entry valid/ready buffer; top instantiates it five times and packs/unpacks structs.

## Test plan
- Reset: hold aresetn=0 10 cycles with s_axi_awvalid=1 → all valid/ready outputs 0; after release awready=1 next cycle.
- Single write: AW addr=0x1000 len=0 size=5 burst=1, W data=0xA5..A5 strb=0xFFFFFFFF last=1, m_axi ready=1 → m_axi beats 1 cycle later, identical fields; m_axi_bvalid bresp=0 → s_axi_bvalid bresp=0 after 1 cycle.
- Burst read: AR addr=0x2000 len=3; m_axi returns 4 R beats data=0..3, rlast on beat 3 → s_axi sees same 4 beats in order, rlast only on last, back-to-back.
- Back-pressure: m_axi_wready=0, push 3 W beats → 2 accepted, s_axi_wready=0; raise wready → beats emerge in order, wready returns 1.
- Reset mid-burst: assert aresetn=0 during 4-beat write after 2 beats → outputs clear; after release a fresh transaction passes with no stale beats.
- Concurrent: simultaneous AW/W/AR/R/B traffic with random ready toggling → per-channel order and payload preserved, no beat lost or duplicated.

Source files
------------

// File: rtl/axi_cc_pkg.sv
// Shared widths and per-channel payload layouts for the AXI channel decoupler.
package axi_cc_pkg;

  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 256;
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  localparam int AX_WIDTH = ADDR_WIDTH + 29;
  localparam int AW_WIDTH = AX_WIDTH;
  localparam int AR_WIDTH = AX_WIDTH;
  localparam int W_WIDTH  = DATA_WIDTH + STRB_WIDTH + 1;
  localparam int B_WIDTH  = 2;
  localparam int R_WIDTH  = DATA_WIDTH + 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
    logic                  lock;
    logic [3:0]            cache;
    logic [2:0]            prot;
    logic [3:0]            region;
    logic [3:0]            qos;
  } ax_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [STRB_WIDTH-1:0] strb;
    logic                  last;
  } w_t;

  typedef struct packed {
    logic [1:0] resp;
  } b_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } r_t;

endpackage

// File: rtl/axi_cc_chan_buf.sv
// Two-entry valid/ready buffer with registered ready, valid and head payload.
module axi_cc_chan_buf #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  logic [1:0]       r_cnt;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic             r_in_rdy;
  logic             r_out_vld;

  logic       w_push;
  logic       w_pop;
  logic [1:0] w_cnt_nxt;

  assign w_push  = i_valid & r_in_rdy;
  assign w_pop   = r_out_vld & i_ready;
  assign o_ready = r_in_rdy;
  assign o_valid = r_out_vld;
  assign o_data  = r_head;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)
      w_cnt_nxt = r_cnt + 2'd1;
    else if (w_pop && !w_push)
      w_cnt_nxt = r_cnt - 2'd1;
  end

  // Head is the output register; tail only fills while head is held.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_head    <= '0;
      r_tail    <= '0;
      r_in_rdy  <= 1'b0;
      r_out_vld <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_in_rdy  <= (w_cnt_nxt != 2'd2);
      r_out_vld <= (w_cnt_nxt != 2'd0);
      if (w_push) begin
        if (r_cnt == 2'd0 || (r_cnt == 2'd1 && w_pop))
          r_head <= i_data;
        else
          r_tail <= i_data;
      end
      if (w_pop && r_cnt == 2'd2)
        r_head <= r_tail;
    end
  end

endmodule

// File: rtl/axi_clock_converter.sv
// AXI4 five-channel decoupler: each channel passes through its own 2-entry buffer.
module axi_clock_converter
  import axi_cc_pkg::*;
(
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic [3:0]            s_axi_awregion,
  input  logic [3:0]            s_axi_awqos,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic [3:0]            s_axi_arregion,
  input  logic [3:0]            s_axi_arqos,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_aresetn,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic [3:0]            m_axi_awregion,
  output logic [3:0]            m_axi_awqos,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic [3:0]            m_axi_arregion,
  output logic [3:0]            m_axi_arqos,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  ax_t w_aw_s, w_aw_m;
  ax_t w_ar_s, w_ar_m;
  w_t  w_w_s,  w_w_m;
  b_t  w_b_m,  w_b_s;
  r_t  w_r_m,  w_r_s;

  // The m-side clock/reset exist only for drop-in compatibility.
  logic w_unused;
  assign w_unused = m_axi_aclk ^ m_axi_aresetn;

  assign w_aw_s = {s_axi_awaddr, s_axi_awlen, s_axi_awsize,
                   s_axi_awburst, s_axi_awlock, s_axi_awcache,
                   s_axi_awprot, s_axi_awregion, s_axi_awqos};
  assign w_ar_s = {s_axi_araddr, s_axi_arlen, s_axi_arsize,
                   s_axi_arburst, s_axi_arlock, s_axi_arcache,
                   s_axi_arprot, s_axi_arregion, s_axi_arqos};
  assign w_w_s  = {s_axi_wdata, s_axi_wstrb, s_axi_wlast};
  assign w_b_m  = m_axi_bresp;
  assign w_r_m  = {m_axi_rdata, m_axi_rresp, m_axi_rlast};

  assign m_axi_awaddr   = w_aw_m.addr;
  assign m_axi_awlen    = w_aw_m.len;
  assign m_axi_awsize   = w_aw_m.size;
  assign m_axi_awburst  = w_aw_m.burst;
  assign m_axi_awlock   = w_aw_m.lock;
  assign m_axi_awcache  = w_aw_m.cache;
  assign m_axi_awprot   = w_aw_m.prot;
  assign m_axi_awregion = w_aw_m.region;
  assign m_axi_awqos    = w_aw_m.qos;

  assign m_axi_araddr   = w_ar_m.addr;
  assign m_axi_arlen    = w_ar_m.len;
  assign m_axi_arsize   = w_ar_m.size;
  assign m_axi_arburst  = w_ar_m.burst;
  assign m_axi_arlock   = w_ar_m.lock;
  assign m_axi_arcache  = w_ar_m.cache;
  assign m_axi_arprot   = w_ar_m.prot;
  assign m_axi_arregion = w_ar_m.region;
  assign m_axi_arqos    = w_ar_m.qos;

  assign m_axi_wdata = w_w_m.data;
  assign m_axi_wstrb = w_w_m.strb;
  assign m_axi_wlast = w_w_m.last;
  assign s_axi_bresp = w_b_s.resp;
  assign s_axi_rdata = w_r_s.data;
  assign s_axi_rresp = w_r_s.resp;
  assign s_axi_rlast = w_r_s.last;

  axi_cc_chan_buf #(.WIDTH(AW_WIDTH)) u_aw (
    .i_clk(s_axi_aclk), .i_rst_n(s_axi_aresetn),
    .i_data(w_aw_s), .i_valid(s_axi_awvalid), .o_ready(s_axi_awready),
    .o_data(w_aw_m), .o_valid(m_axi_awvalid), .i_ready(m_axi_awready)
  );

  axi_cc_chan_buf #(.WIDTH(W_WIDTH)) u_w (
    .i_clk(s_axi_aclk), .i_rst_n(s_axi_aresetn),
    .i_data(w_w_s), .i_valid(s_axi_wvalid), .o_ready(s_axi_wready),
    .o_data(w_w_m), .o_valid(m_axi_wvalid), .i_ready(m_axi_wready)
  );

  axi_cc_chan_buf #(.WIDTH(AR_WIDTH)) u_ar (
    .i_clk(s_axi_aclk), .i_rst_n(s_axi_aresetn),
    .i_data(w_ar_s), .i_valid(s_axi_arvalid), .o_ready(s_axi_arready),
    .o_data(w_ar_m), .o_valid(m_axi_arvalid), .i_ready(m_axi_arready)
  );

  axi_cc_chan_buf #(.WIDTH(B_WIDTH)) u_b (
    .i_clk(s_axi_aclk), .i_rst_n(s_axi_aresetn),
    .i_data(w_b_m), .i_valid(m_axi_bvalid), .o_ready(m_axi_bready),
    .o_data(w_b_s), .o_valid(s_axi_bvalid), .i_ready(s_axi_bready)
  );

  axi_cc_chan_buf #(.WIDTH(R_WIDTH)) u_r (
    .i_clk(s_axi_aclk), .i_rst_n(s_axi_aresetn),
    .i_data(w_r_m), .i_valid(m_axi_rvalid), .o_ready(m_axi_rready),
    .o_data(w_r_s), .o_valid(s_axi_rvalid), .i_ready(s_axi_rready)
  );

endmodule

// File: tb/tb_axi_clock_converter.sv
// Randomized bench with a per-channel ordered-queue model of the decoupler.
module tb_axi_clock_converter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Channel index: 0 AW, 1 W, 2 AR, 3 B, 4 R
  logic [288:0] in_d[5];
  logic         in_v[5];
  logic         out_r[5];

  logic [288:0] q[5][$];
  logic [288:0] last[5];
  bit           alive;
  int           wid[5] = '{61, 289, 61, 2, 259};
  int           ncmp = 0;
  int           nfail = 0;

  logic         s_awready, s_wready, s_arready, s_bvalid, s_rvalid;
  logic [1:0]   s_bresp, s_rresp;
  logic [255:0] s_rdata;
  logic         s_rlast;
  logic [31:0]  m_awaddr, m_araddr;
  logic [7:0]   m_awlen, m_arlen;
  logic [2:0]   m_awsize, m_arsize, m_awprot, m_arprot;
  logic [1:0]   m_awburst, m_arburst;
  logic         m_awlock, m_arlock;
  logic [3:0]   m_awcache, m_arcache, m_awregion, m_arregion;
  logic [3:0]   m_awqos, m_arqos;
  logic         m_awvalid, m_arvalid, m_wvalid, m_wlast;
  logic [255:0] m_wdata;
  logic [31:0]  m_wstrb;
  logic         m_bready, m_rready;

  axi_clock_converter dut (
    .s_axi_aclk(clk), .s_axi_aresetn(rst_n),
    .s_axi_awaddr(in_d[0][60:29]), .s_axi_awlen(in_d[0][28:21]),
    .s_axi_awsize(in_d[0][20:18]), .s_axi_awburst(in_d[0][17:16]),
    .s_axi_awlock(in_d[0][15]), .s_axi_awcache(in_d[0][14:11]),
    .s_axi_awprot(in_d[0][10:8]), .s_axi_awregion(in_d[0][7:4]),
    .s_axi_awqos(in_d[0][3:0]), .s_axi_awvalid(in_v[0]),
    .s_axi_awready(s_awready),
    .s_axi_wdata(in_d[1][288:33]), .s_axi_wstrb(in_d[1][32:1]),
    .s_axi_wlast(in_d[1][0]), .s_axi_wvalid(in_v[1]),
    .s_axi_wready(s_wready),
    .s_axi_bresp(s_bresp), .s_axi_bvalid(s_bvalid), .s_axi_bready(out_r[3]),
    .s_axi_araddr(in_d[2][60:29]), .s_axi_arlen(in_d[2][28:21]),
    .s_axi_arsize(in_d[2][20:18]), .s_axi_arburst(in_d[2][17:16]),
    .s_axi_arlock(in_d[2][15]), .s_axi_arcache(in_d[2][14:11]),
    .s_axi_arprot(in_d[2][10:8]), .s_axi_arregion(in_d[2][7:4]),
    .s_axi_arqos(in_d[2][3:0]), .s_axi_arvalid(in_v[2]),
    .s_axi_arready(s_arready),
    .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rlast(s_rlast),
    .s_axi_rvalid(s_rvalid), .s_axi_rready(out_r[4]),
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen),
    .m_axi_awsize(m_awsize), .m_axi_awburst(m_awburst),
    .m_axi_awlock(m_awlock), .m_axi_awcache(m_awcache),
    .m_axi_awprot(m_awprot), .m_axi_awregion(m_awregion),
    .m_axi_awqos(m_awqos), .m_axi_awvalid(m_awvalid),
    .m_axi_awready(out_r[0]),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast),
    .m_axi_wvalid(m_wvalid), .m_axi_wready(out_r[1]),
    .m_axi_bresp(in_d[3][1:0]), .m_axi_bvalid(in_v[3]),
    .m_axi_bready(m_bready),
    .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen),
    .m_axi_arsize(m_arsize), .m_axi_arburst(m_arburst),
    .m_axi_arlock(m_arlock), .m_axi_arcache(m_arcache),
    .m_axi_arprot(m_arprot), .m_axi_arregion(m_arregion),
    .m_axi_arqos(m_arqos), .m_axi_arvalid(m_arvalid),
    .m_axi_arready(out_r[2]),
    .m_axi_rdata(in_d[4][258:3]), .m_axi_rresp(in_d[4][2:1]),
    .m_axi_rlast(in_d[4][0]), .m_axi_rvalid(in_v[4]),
    .m_axi_rready(m_rready)
  );

  function automatic logic [288:0] msk(int c);
    logic [288:0] ones;
    ones = '1;
    return ones >> (289 - wid[c]);
  endfunction

  function automatic logic [288:0] rnd(int c);
    logic [319:0] t;
    for (int i = 0; i < 10; i++) t[i*32 +: 32] = $urandom;
    return t[288:0] & msk(c);
  endfunction

  function automatic logic got_rdy(int c);
    case (c)
      0: return s_awready;
      1: return s_wready;
      2: return s_arready;
      3: return m_bready;
      default: return m_rready;
    endcase
  endfunction

  function automatic logic got_vld(int c);
    case (c)
      0: return m_awvalid;
      1: return m_wvalid;
      2: return m_arvalid;
      3: return s_bvalid;
      default: return s_rvalid;
    endcase
  endfunction

  function automatic logic [288:0] got_dat(int c);
    case (c)
      0: return {228'd0, m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock,
                 m_awcache, m_awprot, m_awregion, m_awqos};
      1: return {m_wdata, m_wstrb, m_wlast};
      2: return {228'd0, m_araddr, m_arlen, m_arsize, m_arburst, m_arlock,
                 m_arcache, m_arprot, m_arregion, m_arqos};
      3: return {287'd0, s_bresp};
      default: return {30'd0, s_rdata, s_rresp, s_rlast};
    endcase
  endfunction

  task automatic chk(string name, logic [288:0] act, logic [288:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Compare every channel against the queue model, then apply this edge's handshakes.
  task automatic model_step();
    string nm[5] = '{"aw", "w", "ar", "b", "r"};
    for (int c = 0; c < 5; c++) begin
      logic er, ev;
      logic [288:0] ed;
      er = alive && (q[c].size() < 2);
      ev = q[c].size() > 0;
      ed = ev ? q[c][0] : last[c];
      chk({nm[c], "_in_ready"}, {288'd0, got_rdy(c)}, {288'd0, er});
      chk({nm[c], "_out_valid"}, {288'd0, got_vld(c)}, {288'd0, ev});
      chk({nm[c], "_out_data"}, got_dat(c), ed);
      if (!rst_n) begin
        q[c].delete();
        last[c] = '0;
      end else begin
        if (ev && out_r[c]) last[c] = q[c].pop_front();
        if (in_v[c] && er) q[c].push_back(in_d[c] & msk(c));
      end
    end
    alive = rst_n;
  endtask

  task automatic step();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int c = 0; c < 5; c++) in_v[c] = 1'b0;
  endtask

  initial begin
    logic [288:0] wbeat[3];
    rst_n = 1'b0;
    alive = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_d[c] = '0;
      in_v[c] = 1'b0;
      out_r[c] = 1'b1;
      last[c] = '0;
    end
    in_v[0] = 1'b1;
    in_d[0] = rnd(0);
    @(posedge clk);
    #1;

    // Reset held with awvalid high
    for (int i = 0; i < 10; i++) step();
    chk("rst_awready", {288'd0, s_awready}, 289'd0);
    chk("rst_wready", {288'd0, s_wready}, 289'd0);
    chk("rst_m_awvalid", {288'd0, m_awvalid}, 289'd0);
    rst_n = 1'b1;
    step();
    chk("rel_awready", {288'd0, s_awready}, 289'd1);
    chk("rel_no_push", {288'd0, m_awvalid}, 289'd0);
    idle_inputs();
    step();

    // Single write
    in_d[0] = {32'h1000, 8'd0, 3'd5, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0};
    in_d[1] = {{32{8'hA5}}, 32'hFFFF_FFFF, 1'b1};
    in_v[0] = 1'b1;
    in_v[1] = 1'b1;
    step();
    idle_inputs();
    chk("sw_awaddr", {257'd0, m_awaddr}, {257'd0, 32'h1000});
    chk("sw_awsize", {286'd0, m_awsize}, 289'd5);
    chk("sw_wdata", {33'd0, m_wdata}, {33'd0, {32{8'hA5}}});
    chk("sw_wvalid", {288'd0, m_wvalid}, 289'd1);
    in_d[3] = '0;
    in_v[3] = 1'b1;
    step();
    in_v[3] = 1'b0;
    chk("sw_bvalid", {288'd0, s_bvalid}, 289'd1);
    chk("sw_bresp", {287'd0, s_bresp}, 289'd0);
    step();

    // Burst read of 4 beats
    in_d[2] = {32'h2000, 8'd3, 3'd5, 2'd1, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0};
    in_v[2] = 1'b1;
    step();
    in_v[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_d[4] = {30'd0, 256'(i), 2'b00, (i == 3)};
      in_v[4] = 1'b1;
      step();
    end
    in_v[4] = 1'b0;
    chk("br_rdata3", {33'd0, s_rdata}, 289'd3);
    chk("br_rlast3", {288'd0, s_rlast}, 289'd1);
    for (int i = 0; i < 3; i++) step();

    // Back-pressure on W
    out_r[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wbeat[i] = rnd(1);
      in_d[1] = wbeat[i];
      in_v[1] = 1'b1;
      step();
    end
    chk("bp_wready_low", {288'd0, s_wready}, 289'd0);
    chk("bp_head", {m_wdata, m_wstrb, m_wlast}, wbeat[0]);
    out_r[1] = 1'b1;
    step();
    chk("bp_wready_back", {288'd0, s_wready}, 289'd1);
    step();
    in_v[1] = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Reset in the middle of a 4-beat write
    out_r[1] = 1'b0;
    in_d[0] = rnd(0);
    in_v[0] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_d[1] = rnd(1);
      in_v[1] = 1'b1;
      step();
      in_v[0] = 1'b0;
    end
    idle_inputs();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("mid_wvalid", {288'd0, m_wvalid}, 289'd0);
    chk("mid_wdata", {33'd0, m_wdata}, 289'd0);
    rst_n = 1'b1;
    out_r[1] = 1'b1;
    step();
    wbeat[0] = rnd(1);
    in_d[1] = wbeat[0];
    in_v[1] = 1'b1;
    step();
    in_v[1] = 1'b0;
    chk("mid_fresh", {m_wdata, m_wstrb, m_wlast}, wbeat[0]);
    step();
    chk("mid_no_stale", {288'd0, m_wvalid}, 289'd0);

    // Concurrent random traffic with random readies
    for (int n = 0; n < 2000; n++) begin
      for (int c = 0; c < 5; c++) begin
        in_v[c] = ($urandom_range(0, 3) != 0);
        in_d[c] = rnd(c);
        out_r[c] = ($urandom_range(0, 2) != 0);
      end
      step();
    end
    idle_inputs();
    for (int c = 0; c < 5; c++) out_r[c] = 1'b1;
    for (int i = 0; i < 4; i++) step();
    for (int c = 0; c < 5; c++)
      chk("drain_empty", 289'(q[c].size()), 289'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", ncmp, nfail);
    $finish;
  end

endmodule
